// File: rtl/dut_pkg.sv
// Shared constants and helpers for the A/B and C/D stages of dut.
package dut_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    // True when a counter value is at its wrap point.
    function automatic logic is_wrap(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX);
    endfunction

endpackage

// File: rtl/dut_ab_stage.sv
// A/B stage: registers the XOR of the two data inputs.
module ab_stage
    import dut_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic E,
    output logic B
);

    // B follows A^E one cycle later; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            B <= 1'b0;
        end else begin
            B <= A ^ E;
        end
    end

endmodule

// File: rtl/dut_cd_stage.sv
// C/D stage: counts cycles with B high and flags each counter wrap.
module cd_stage
    import dut_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             B,
    output logic [CNT_W-1:0] Count,
    output logic             D
);

    // Count advances on the registered B; D pulses on the edge the count wraps to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Count <= '0;
            D     <= 1'b0;
        end else begin
            if (B) begin
                Count <= Count + 4'd1;
            end
            D <= B && is_wrap(Count);
        end
    end

endmodule

// File: rtl/dut.sv
// Top level: optional A/B stage feeding an optional C/D stage.
module dut
    import dut_pkg::*;
#(
    parameter int initA = 1,
    parameter int initC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A,
    input  logic             E,
    output logic             B,
    output logic [CNT_W-1:0] Count,
    output logic             D
);

    logic             b_int;
    logic [CNT_W-1:0] count_int;
    logic             d_int;

    if (initA != 0) begin : A_blk
        ab_stage A_mod (
            .clk   (clk),
            .reset (reset),
            .A     (A),
            .E     (E),
            .B     (b_int)
        );
    end else begin : A_off
        // Without the A stage the C/D stage sees a constant-low B.
        assign b_int = 1'b0;
    end

    if (initC != 0) begin : C_blk
        cd_stage C_mod (
            .clk   (clk),
            .reset (reset),
            .B     (b_int),
            .Count (count_int),
            .D     (d_int)
        );
    end else begin : C_off
        assign count_int = '0;
        assign d_int     = 1'b0;
    end

    assign B     = b_int;
    assign Count = count_int;
    assign D     = d_int;

endmodule

// File: tb/tb_dut.sv
// Directed bench for dut in three build variants sharing one stimulus.
module tb_dut;

    logic       clk = 1'b0;
    logic       reset;
    logic       A;
    logic       E;

    logic       b_def, d_def;
    logic [3:0] cnt_def;
    logic       b_na, d_na;
    logic [3:0] cnt_na;
    logic       b_nc, d_nc;
    logic [3:0] cnt_nc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dut #(.initA(1), .initC(1)) u_def (
        .clk(clk), .reset(reset), .A(A), .E(E),
        .B(b_def), .Count(cnt_def), .D(d_def)
    );

    dut #(.initA(0), .initC(1)) u_na (
        .clk(clk), .reset(reset), .A(A), .E(E),
        .B(b_na), .Count(cnt_na), .D(d_na)
    );

    dut #(.initA(1), .initC(0)) u_nc (
        .clk(clk), .reset(reset), .A(A), .E(E),
        .B(b_nc), .Count(cnt_nc), .D(d_nc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs of the two variants whose count stage is absent or starved.
    task automatic check_variants(input logic exp_b);
        check("na_B", {31'd0, b_na}, 32'd0);
        check("na_Count", {28'd0, cnt_na}, 32'd0);
        check("na_D", {31'd0, d_na}, 32'd0);
        check("nc_B", {31'd0, b_nc}, {31'd0, exp_b});
        check("nc_Count", {28'd0, cnt_nc}, 32'd0);
        check("nc_D", {31'd0, d_nc}, 32'd0);
    endtask

    initial begin
        logic exp_b;

        // Reset held two edges with A=1, E=0
        reset = 1'b0; A = 1'b1; E = 1'b0;
        step();
        step();
        check("rst_B", {31'd0, b_def}, 32'd0);
        check("rst_Count", {28'd0, cnt_def}, 32'd0);
        check("rst_D", {31'd0, d_def}, 32'd0);
        check_variants(1'b0);

        // First edge after release: B loads A^E, Count/D see old B=0
        reset = 1'b1;
        step();
        check("rel_B", {31'd0, b_def}, 32'd1);
        check("rel_Count", {28'd0, cnt_def}, 32'd0);
        check("rel_D", {31'd0, d_def}, 32'd0);
        check_variants(1'b1);

        // XOR vectors: (0,0)->0, (1,1)->0, (1,0)->1
        A = 1'b0; E = 1'b0; step();
        check("xor00_B", {31'd0, b_def}, 32'd0);
        check("xor00_Count", {28'd0, cnt_def}, 32'd1);
        A = 1'b1; E = 1'b1; step();
        check("xor11_B", {31'd0, b_def}, 32'd0);
        A = 1'b1; E = 1'b0; step();
        check("xor10_B", {31'd0, b_def}, 32'd1);
        check("xor_Count", {28'd0, cnt_def}, 32'd1);
        A = 1'b0; E = 1'b1; step();
        check("xor01_B", {31'd0, b_def}, 32'd1);
        check("xor01_Count", {28'd0, cnt_def}, 32'd2);

        // Clear, then hold A^E=1: edge k gives Count=(k-1) mod 16, D only at k=17
        reset = 1'b0; step();
        check("clr_Count", {28'd0, cnt_def}, 32'd0);
        reset = 1'b1; A = 1'b1; E = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            step();
            check($sformatf("wrap_B_%0d", k), {31'd0, b_def}, 32'd1);
            check($sformatf("wrap_Count_%0d", k), {28'd0, cnt_def}, (k - 1) % 16);
            check($sformatf("wrap_D_%0d", k), {31'd0, d_def}, (k == 17) ? 32'd1 : 32'd0);
            check($sformatf("wrap_hierD_%0d", k), {31'd0, u_def.C_blk.C_mod.D}, (k == 17) ? 32'd1 : 32'd0);
            check_variants(1'b1);
        end

        // Reach Count=7 then reset mid-count
        reset = 1'b0; step();
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        check("mid_Count", {28'd0, cnt_def}, 32'd7);
        reset = 1'b0; step();
        check("midrst_B", {31'd0, b_def}, 32'd0);
        check("midrst_Count", {28'd0, cnt_def}, 32'd0);
        check("midrst_D", {31'd0, d_def}, 32'd0);
        check_variants(1'b0);

        // Toggle A/E for 20 edges; B tracks A^E one edge later
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            A = i[0];
            E = i[1];
            exp_b = i[0] ^ i[1];
            step();
            check($sformatf("tog_B_%0d", i), {31'd0, b_def}, {31'd0, exp_b});
            check($sformatf("tog_hierE_%0d", i), {31'd0, u_nc.A_blk.A_mod.E}, {31'd0, E});
            check_variants(exp_b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
